// File: rtl/audio_voice_sched.sv
// Four-voice audio mixer scheduler: scans voices once per frame, sums, attenuates and saturates.
// Optional per-voice mute input is enabled by defining AUDIO_VOICE_MUTE_EN.
module audio_voice_sched #(
    parameter int ATTEN_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_sample,
    input  logic [3:0]  voice_req,
    input  logic [95:0] voice_l,
    input  logic [95:0] voice_r,
`ifdef AUDIO_VOICE_MUTE_EN
    input  logic [3:0]  mute,
`endif
    output logic [3:0]  voice_ack,
    output logic [23:0] audio_l_out,
    output logic [23:0] audio_r_out,
    output logic        busy,
    output logic        mix_done,
    output logic        overrun
);

    // state | meaning
    // IDLE  | waiting for new_sample; outputs hold last mix
    // SCAN  | one voice per cycle, voice 0..3, accumulate requested samples
    // SAT   | attenuate and saturate sums, register outputs
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam logic signed [25:0] SAT_MAX = 26'sd8388607;
    localparam logic signed [25:0] SAT_MIN = -26'sd8388608;

    state_t state_q, state_d;
    logic [1:0] scan_left_q, scan_left_d;
    logic [1:0] voice_idx;
    logic [3:0] req_eff;
    logic       take;
    logic       frame_start;

    logic [23:0]        sel_l, sel_r;
    logic signed [25:0] ext_l, ext_r;
    logic signed [25:0] acc_l_q, acc_r_q;
    logic signed [25:0] shf_l, shf_r;
    logic [23:0]        sat_l, sat_r;

`ifdef AUDIO_VOICE_MUTE_EN
    assign req_eff = voice_req & ~mute;
`else
    assign req_eff = voice_req;
`endif

    // scan counter runs 3..0, so the voice being scanned is its complement
    assign voice_idx = 2'd3 - scan_left_q;

    assign sel_l = voice_l[voice_idx*24 +: 24];
    assign sel_r = voice_r[voice_idx*24 +: 24];
    assign ext_l = {{2{sel_l[23]}}, sel_l};
    assign ext_r = {{2{sel_r[23]}}, sel_r};

    // a reset cycle consumes nothing, so an abandoned frame never acks
    assign take = (state_q == SCAN) && req_eff[voice_idx] && !rst;

    assign shf_l = acc_l_q >>> ATTEN_SHIFT;
    assign shf_r = acc_r_q >>> ATTEN_SHIFT;

    function automatic logic [23:0] sat24(input logic signed [25:0] v);
        if (v > SAT_MAX) begin
            return 24'h7FFFFF;
        end else if (v < SAT_MIN) begin
            return 24'h800000;
        end else begin
            return v[23:0];
        end
    endfunction

    assign sat_l = sat24(shf_l);
    assign sat_r = sat24(shf_r);

    always_comb begin
        state_d     = state_q;
        scan_left_d = scan_left_q;
        frame_start = 1'b0;
        voice_ack   = 4'b0000;
        case (state_q)
            IDLE: begin
                if (new_sample) begin
                    state_d     = SCAN;
                    scan_left_d = 2'd3;
                    frame_start = 1'b1;
                end
            end
            SCAN: begin
                if (take) begin
                    voice_ack = 4'b0001 << voice_idx;
                end
                if (scan_left_q == 2'd0) begin
                    state_d = SAT;
                end else begin
                    scan_left_d = scan_left_q - 2'd1;
                end
            end
            SAT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scan_left_q <= 2'd0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            audio_l_out <= '0;
            audio_r_out <= '0;
            mix_done    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_left_q <= scan_left_d;
            mix_done    <= (state_q == SAT);
            if (new_sample && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
            if (frame_start) begin
                acc_l_q <= '0;
                acc_r_q <= '0;
            end else if (take) begin
                acc_l_q <= acc_l_q + ext_l;
                acc_r_q <= acc_r_q + ext_r;
            end
            if (state_q == SAT) begin
                audio_l_out <= sat_l;
                audio_r_out <= sat_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_voice_sched.sv
// Bench for audio_voice_sched: three instances (ATTEN_SHIFT 0,1,2) against a frame-level model.
// Honours AUDIO_VOICE_MUTE_EN when defined.
module tb_audio_voice_sched;

    logic        clk;
    logic        rst;
    logic        new_sample;
    logic [3:0]  voice_req;
    logic [95:0] voice_l;
    logic [95:0] voice_r;
    logic [3:0]  mute_v;
`ifdef AUDIO_VOICE_MUTE_EN
    logic [3:0]  mute;
    assign mute_v = mute;
`else
    assign mute_v = 4'b0000;
`endif

    logic [3:0]  ack  [3];
    logic [23:0] aud_l [3];
    logic [23:0] aud_r [3];
    logic        busy [3];
    logic        done [3];
    logic        ovr  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        audio_voice_sched #(.ATTEN_SHIFT(g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .new_sample (new_sample),
            .voice_req  (voice_req),
            .voice_l    (voice_l),
            .voice_r    (voice_r),
`ifdef AUDIO_VOICE_MUTE_EN
            .mute       (mute),
`endif
            .voice_ack  (ack[g]),
            .audio_l_out(aud_l[g]),
            .audio_r_out(aud_r[g]),
            .busy       (busy[g]),
            .mix_done   (done[g]),
            .overrun    (ovr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    // Frame model: phase 0 = idle, 1..4 = scanning voice phase-1, 5 = saturate
    int m_phase = 0;
    int m_sum_l = 0, m_sum_r = 0;
    int m_out_l[3] = '{0, 0, 0};
    int m_out_r[3] = '{0, 0, 0};
    int m_done = 0;
    int m_ovr  = 0;

    always @(negedge clk) begin : cmp
        int sl[4];
        int sr[4];
        logic [3:0] req_e;
        int exp_ack;
        req_e = voice_req & ~mute_v;
        for (int i = 0; i < 4; i++) begin
            sl[i] = int'($signed(voice_l[24*i +: 24]));
            sr[i] = int'($signed(voice_r[24*i +: 24]));
        end
        exp_ack = 0;
        if (m_phase >= 1 && m_phase <= 4 && !rst && req_e[m_phase-1])
            exp_ack = 1 << (m_phase - 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ack s%0d", k),   int'(ack[k]), exp_ack);
            check($sformatf("busy s%0d", k),  int'(busy[k]), int'(m_phase != 0));
            check($sformatf("out_l s%0d", k), int'($signed(aud_l[k])), m_out_l[k]);
            check($sformatf("out_r s%0d", k), int'($signed(aud_r[k])), m_out_r[k]);
            check($sformatf("done s%0d", k),  int'(done[k]), m_done);
            check($sformatf("ovr s%0d", k),   int'(ovr[k]), m_ovr);
        end
        if (rst) begin
            m_phase = 0; m_sum_l = 0; m_sum_r = 0; m_done = 0; m_ovr = 0;
            for (int k = 0; k < 3; k++) begin
                m_out_l[k] = 0; m_out_r[k] = 0;
            end
        end else begin
            if (m_phase == 5) begin
                for (int k = 0; k < 3; k++) begin
                    m_out_l[k] = sat(m_sum_l >>> k);
                    m_out_r[k] = sat(m_sum_r >>> k);
                end
            end
            m_done = (m_phase == 5) ? 1 : 0;
            if (new_sample && m_phase != 0) m_ovr = 1;
            if (m_phase >= 1 && m_phase <= 4 && req_e[m_phase-1]) begin
                m_sum_l += sl[m_phase-1];
                m_sum_r += sr[m_phase-1];
            end
            if (m_phase == 0) begin
                if (new_sample) begin
                    m_phase = 1; m_sum_l = 0; m_sum_r = 0;
                end
            end else if (m_phase == 5) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    end

    // inputs change only just after a rising edge
    task automatic cyc(input logic ns, input logic [3:0] rq);
        new_sample = ns;
        voice_req  = rq;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [3:0] rq);
        cyc(1'b1, rq);
        repeat (5) cyc(1'b0, rq);
    endtask

    task automatic peek(input string nm, input int k, input bit chk_out, input int el, input int er,
                        input int ed, input int eb, input int eo);
        new_sample = 1'b0;
        @(negedge clk);
        if (chk_out) begin
            check({nm, " lit_l"}, int'($signed(aud_l[k])), el);
            check({nm, " lit_r"}, int'($signed(aud_r[k])), er);
        end
        check({nm, " lit_done"}, int'(done[k]), ed);
        check({nm, " lit_busy"}, int'(busy[k]), eb);
        check({nm, " lit_ovr"},  int'(ovr[k]), eo);
        @(posedge clk); #1;
    endtask

    task automatic set_all(input logic [23:0] l, input logic [23:0] r);
        voice_l = {4{l}};
        voice_r = {4{r}};
    endtask

    initial begin
        rst = 1'b1; new_sample = 1'b0; voice_req = 4'b0;
        voice_l = '0; voice_r = '0;
`ifdef AUDIO_VOICE_MUTE_EN
        mute = 4'b0000;
`endif
        @(posedge clk); #1;
        cyc(1'b0, 4'b0);
        peek("reset", 0, 1'b1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1'b0, 4'b0);

        set_all(24'd100, -24'sd50);
        frame(4'b1111);
        peek("mix100 s0", 0, 1'b1, 400, -200, 1, 0, 0);
        frame(4'b1111);
        peek("mix100 s1", 1, 1'b1, 200, -100, 1, 0, 0);

        set_all(24'd8000000, -24'sd8000000);
        frame(4'b1111);
        peek("satpos s0", 0, 1'b1, 8388607, -8388608, 1, 0, 0);
        frame(4'b1111);
        peek("sat s2", 2, 1'b1, 8000000, -8000000, 1, 0, 0);

        voice_l = {24'd0, -24'sd3000, 24'd0, 24'd1000};
        voice_r = '0;
        frame(4'b0101);
        peek("req0101 s1", 1, 1'b1, -1000, 0, 1, 0, 0);

        // second pulse inside a frame is dropped but flags overrun
        set_all(24'd100, -24'sd50);
        cyc(1'b1, 4'b1111);
        cyc(1'b0, 4'b1111);
        cyc(1'b0, 4'b1111);
        cyc(1'b1, 4'b1111);
        peek("ovr c4", 0, 1'b0, 0, 0, 0, 1, 1);
        cyc(1'b0, 4'b1111);
        frame(4'b1111);
        peek("ovr frame2", 0, 1'b1, 400, -200, 1, 0, 1);

        // reset in cycle 2 abandons the frame
        cyc(1'b1, 4'b1111);
        cyc(1'b0, 4'b1111);
        rst = 1'b1;
        cyc(1'b0, 4'b1111);
        rst = 1'b0;
        peek("rst c3", 0, 1'b1, 0, 0, 0, 0, 0);
        repeat (4) peek("rst after", 0, 1'b1, 0, 0, 0, 0, 0);

        // reset wins over a simultaneous frame start
        rst = 1'b1;
        cyc(1'b1, 4'b1111);
        rst = 1'b0;
        peek("rst+ns", 0, 1'b1, 0, 0, 0, 0, 0);

`ifdef AUDIO_VOICE_MUTE_EN
        mute = 4'b0010;
        set_all(24'd10, 24'd0);
        frame(4'b1111);
        peek("mute s0", 0, 1'b1, 30, 0, 1, 0, 0);
        mute = 4'b0000;
`endif

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            voice_l = {$urandom, $urandom, $urandom};
            voice_r = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) voice_l = {4{24'h000010}} ^ {72'd0, 24'($urandom_range(0, 255))};
`ifdef AUDIO_VOICE_MUTE_EN
            mute = 4'($urandom);
`endif
            cyc(($urandom_range(0, 3) == 0), 4'($urandom));
        end
        rst = 1'b0;
        repeat (8) cyc(1'b0, 4'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_voice_sched.md
AUDIO_VOICE_SCHED -- requirements
Module: audio_voice_sched

Interface
REQ-001 SHALL have parameter ATTEN_SHIFT, default 1, meaning the arithmetic right shift (legal 0..2) applied to the voice sum before saturation.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port new_sample  input  1  one-cycle frame-start pulse from the I2S serializer.
REQ-005 SHALL have port voice_req  input  4  per-voice "sample available" request, bit i for voice i.
REQ-006 SHALL have port voice_l  input  96  four signed 24-bit left samples; voice i in bits [24i+23:24i].
REQ-007 SHALL have port voice_r  input  96  four signed 24-bit right samples, same packing as voice_l.
REQ-008 SHALL have port voice_ack  output  4  one-cycle pulse: voice i sample consumed.
REQ-009 SHALL have port audio_l_out  output  24  signed mixed left sample, to the serializer's left input.
REQ-010 SHALL have port audio_r_out  output  24  signed mixed right sample, to the serializer's right input.
REQ-011 SHALL have port busy  output  1  high while a mix frame is in progress.
REQ-012 SHALL have port mix_done  output  1  one-cycle pulse: new audio_l_out/audio_r_out values are valid.
REQ-013 SHALL have port overrun  output  1  sticky flag: a frame start arrived while busy.

Function
REQ-014 SHALL implement a state machine with states IDLE, SCAN, SAT. IDLE goes to SCAN on new_sample. SCAN runs 4 cycles, then goes to SAT. SAT runs 1 cycle, then goes to IDLE.
REQ-015 SHALL number cycles from the new_sample cycle in IDLE (cycle 0): cycles 1-4 SCAN voice 0..3 in fixed order, cycle 5 SAT.
REQ-016 SHALL, in the SCAN cycle for voice i, check voice_req[i]: if high, pulse voice_ack[i] in that cycle and add that cycle's voice_l/voice_r slice i into the accumulators; if low, add 0 and leave voice_ack[i] low.
REQ-017 SHALL never assert more than one voice_ack bit in any cycle, and SHALL pulse each bit at most once per frame.
REQ-018 SHALL sign-extend each sample to 26 bits and use 26-bit signed accumulators, cleared when a frame starts.
REQ-019 SHALL, in SAT, arithmetic-shift each sum right by ATTEN_SHIFT, then saturate to the range -8388608..8388607.
REQ-020 SHALL register the saturated results to audio_l_out/audio_r_out at the end of cycle 5, so new values are visible from cycle 6 with mix_done high for cycle 6 only.
REQ-021 SHALL hold audio_l_out/audio_r_out unchanged between updates.
REQ-022 SHALL drive busy high in cycles 1-5 and low in IDLE.
REQ-023 SHALL ignore new_sample received in SCAN or SAT (no restart), and SHALL set overrun to 1 the next cycle; overrun stays 1 until reset.
REQ-024 SHALL accept a new_sample arriving in cycle 6 (IDLE) as a new frame; minimum frame spacing is 6 cycles.

Reset
REQ-025 SHALL, on rst high at a clock edge, enter IDLE and clear both accumulators; voice_ack, audio_l_out, audio_r_out, busy, mix_done and overrun SHALL all be 0.
REQ-026 SHALL, when reset asserts mid-frame, abandon the frame: no further voice_ack pulses, no mix_done, outputs read 0.
REQ-027 SHALL give rst priority over a new_sample in the same cycle; that frame start is dropped and does not set overrun.

Configuration
REQ-028 SHALL, with macro AUDIO_VOICE_MUTE_EN defined, add input port mute (4 bits); a muted voice is treated as not requesting (no voice_ack, contributes 0), with mute[i] sampled in voice i's SCAN cycle.
REQ-029 SHALL, without AUDIO_VOICE_MUTE_EN, have no mute port and behave as if mute were 4'b0000.

Verification
REQ-030 SHALL cover: ATTEN_SHIFT=0, req=1111, all voice_l=100, all voice_r=-50, new_sample at cycle 0 -> voice_ack 0001,0010,0100,1000 in cycles 1-4; audio_l_out=400 and audio_r_out=-200 from cycle 6; mix_done in cycle 6.
REQ-031 SHALL cover: ATTEN_SHIFT=0, req=1111, all voice_l=8000000 -> audio_l_out=8388607 (positive saturation); all voice_l=-8000000 -> audio_l_out=-8388608.
REQ-032 SHALL cover: ATTEN_SHIFT=1, req=0101, voice0_l=1000, voice2_l=-3000 -> acks only on bits 0 and 2; audio_l_out=-1000.
REQ-033 SHALL cover: new_sample at cycles 0 and 3 -> a single frame; overrun=1 from cycle 4; the second pulse causes no extra ack; new_sample at cycle 6 -> a second frame.
REQ-034 SHALL cover: rst at cycle 2 of a frame -> voice_ack stays 0 from then on, no mix_done, outputs 0, busy 0 the next cycle.
REQ-035 SHALL cover, with AUDIO_VOICE_MUTE_EN: mute=0010, req=1111, all voice_l=10, ATTEN_SHIFT=0 -> voice_ack[1] never pulses; audio_l_out=30.
